int_div_unit: RTL and testbench

- Parametrised iterative radix-2 integer divider/remainder unit for the execute stage.
- Successor to the single-issue FP divide wrapper: native RTL datapath, configurable width, four RISC-V M-extension modes, fast paths for corner cases, optional early-out.
- Accepts one uop when idle and tracks its sqN for branch-flush kill.
- Holds its result until the writeback port grants it.

---
 rtl/int_div_unit.sv | 174 +++++++++++++++++
 tb/tb_int_div_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_div_unit.sv
// rtl/int_div_unit.sv - iterative radix-2 restoring divider/remainder unit with flush kill
// Optional early-out (leading-zero skip of the dividend) enabled by defining INT_DIV_EARLY_OUT_EN.
module int_div_unit #(
   parameter int WIDTH = 32,
   parameter int SQN_W = 7,
   parameter int TAG_W = 7,
   parameter int NM_W  = 5
) (
   input  logic             clk,
   input  logic             nReset,
   input  logic             IN_valid,
   input  logic [1:0]       IN_op,
   input  logic [WIDTH-1:0] IN_srcA,
   input  logic [WIDTH-1:0] IN_srcB,
   input  logic [SQN_W-1:0] IN_sqN,
   input  logic [TAG_W-1:0] IN_tagDst,
   input  logic [NM_W-1:0]  IN_nmDst,
   input  logic             IN_branchTaken,
   input  logic [SQN_W-1:0] IN_branchSqN,
   input  logic             IN_wbAvail,
   output logic             OUT_busy,
   output logic             OUT_valid,
   output logic [WIDTH-1:0] OUT_result,
   output logic [SQN_W-1:0] OUT_sqN,
   output logic [TAG_W-1:0] OUT_tagDst,
   output logic [NM_W-1:0]  OUT_nmDst,
   output logic             OUT_divZero
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t state, state_nxt;

   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] rem, quot, b_mag;
   logic             op_rem, q_neg, r_neg, div_zero;
   logic [SQN_W-1:0] sqn;
   logic [TAG_W-1:0] tag;
   logic [NM_W-1:0]  nm;

   // Signed modulo compare: a uop is younger than the branch when the wrapped difference is positive.
   function automatic logic kill_f(input logic [SQN_W-1:0] s, input logic taken,
                                   input logic [SQN_W-1:0] br_sqn);
      logic [SQN_W-1:0] d;
      d = s - br_sqn;
      return taken && !d[SQN_W-1] && (d != '0);
   endfunction

`ifdef INT_DIV_EARLY_OUT_EN
   function automatic logic [CNT_W-1:0] lzc(input logic [WIDTH-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < WIDTH; i++)
         if (v[i]) n = CNT_W'(WIDTH - 1 - i);
      return n;
   endfunction
`endif

   logic             is_signed, a_neg, b_neg, b_zero, overflow, special, accept, stored_kill;
   logic [WIDTH-1:0] a_mag, b_mag_in;

   assign is_signed   = !IN_op[0];
   assign a_neg       = is_signed && IN_srcA[WIDTH-1];
   assign b_neg       = is_signed && IN_srcB[WIDTH-1];
   assign a_mag       = a_neg ? -IN_srcA : IN_srcA;
   assign b_mag_in    = b_neg ? -IN_srcB : IN_srcB;
   assign b_zero      = (IN_srcB == '0);
   assign overflow    = is_signed && (IN_srcA == MIN_VAL) && (IN_srcB == '1);
   assign accept      = (state == IDLE) && IN_valid && !kill_f(IN_sqN, IN_branchTaken, IN_branchSqN);
   assign stored_kill = kill_f(sqn, IN_branchTaken, IN_branchSqN);

`ifdef INT_DIV_EARLY_OUT_EN
   logic             a_zero;
   logic [CNT_W-1:0] lz;
   assign a_zero  = (a_mag == '0);
   assign lz      = lzc(a_mag);
   assign special = b_zero || overflow || a_zero;
`else
   assign special = b_zero || overflow;
`endif

   // One restoring step; the shifted partial remainder needs one extra bit before the compare.
   logic [WIDTH:0]   partial;
   logic             ge;
   logic [WIDTH-1:0] rem_step, quot_step, q_fix, r_fix;

   assign partial   = {rem, quot[WIDTH-1]};
   assign ge        = partial >= {1'b0, b_mag};
   assign rem_step  = ge ? (partial[WIDTH-1:0] - b_mag) : partial[WIDTH-1:0];
   assign quot_step = {quot[WIDTH-2:0], ge};
   assign q_fix     = q_neg ? -quot : quot;
   assign r_fix     = r_neg ? -rem : rem;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = special ? FIX : RUN;
         RUN:  if (stored_kill) state_nxt = IDLE;
               else if (count == CNT_W'(1)) state_nxt = FIX;
         FIX:  state_nxt = stored_kill ? IDLE : DONE;
         DONE: if (stored_kill || IN_wbAvail) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) state <= IDLE;
      else         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         count      <= '0;
         rem        <= '0;
         quot       <= '0;
         b_mag      <= '0;
         op_rem     <= 1'b0;
         q_neg      <= 1'b0;
         r_neg      <= 1'b0;
         div_zero   <= 1'b0;
         sqn        <= '0;
         tag        <= '0;
         nm         <= '0;
         OUT_result <= '0;
         OUT_valid  <= 1'b0;
      end else begin
         OUT_valid <= (state_nxt == DONE);
         if (accept) begin
            sqn      <= IN_sqN;
            tag      <= IN_tagDst;
            nm       <= IN_nmDst;
            op_rem   <= IN_op[1];
            div_zero <= b_zero;
            b_mag    <= b_mag_in;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            count    <= CNT_W'(WIDTH);
            if (b_zero) begin
               quot <= '1;
               rem  <= IN_srcA;
            end else if (overflow) begin
               quot <= MIN_VAL;
               rem  <= '0;
            end else begin
               q_neg <= a_neg ^ b_neg;
               r_neg <= a_neg;
               rem   <= '0;
`ifdef INT_DIV_EARLY_OUT_EN
               quot  <= a_mag << lz;
               count <= CNT_W'(WIDTH) - lz;
`else
               quot  <= a_mag;
`endif
            end
         end else if (state == RUN) begin
            rem   <= rem_step;
            quot  <= quot_step;
            count <= count - CNT_W'(1);
         end else if (state == FIX) begin
            OUT_result <= op_rem ? r_fix : q_fix;
         end
      end
   end

   assign OUT_busy    = (state != IDLE);
   assign OUT_sqN     = sqn;
   assign OUT_tagDst  = tag;
   assign OUT_nmDst   = nm;
   assign OUT_divZero = div_zero;

endmodule

// File: tb/tb_int_div_unit.sv
// tb/tb_int_div_unit.sv - randomized and directed self-checking bench for int_div_unit
module tb_int_div_unit;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          nReset;
   logic          IN_valid;
   logic [1:0]    IN_op;
   logic [W-1:0]  IN_srcA, IN_srcB;
   logic [6:0]    IN_sqN, IN_tagDst, IN_branchSqN;
   logic [4:0]    IN_nmDst;
   logic          IN_branchTaken, IN_wbAvail;
   logic          OUT_busy, OUT_valid, OUT_divZero;
   logic [W-1:0]  OUT_result;
   logic [6:0]    OUT_sqN, OUT_tagDst;
   logic [4:0]    OUT_nmDst;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   int_div_unit dut (
      .clk(clk), .nReset(nReset), .IN_valid(IN_valid), .IN_op(IN_op),
      .IN_srcA(IN_srcA), .IN_srcB(IN_srcB), .IN_sqN(IN_sqN), .IN_tagDst(IN_tagDst),
      .IN_nmDst(IN_nmDst), .IN_branchTaken(IN_branchTaken), .IN_branchSqN(IN_branchSqN),
      .IN_wbAvail(IN_wbAvail), .OUT_busy(OUT_busy), .OUT_valid(OUT_valid),
      .OUT_result(OUT_result), .OUT_sqN(OUT_sqN), .OUT_tagDst(OUT_tagDst),
      .OUT_nmDst(OUT_nmDst), .OUT_divZero(OUT_divZero)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] ref_res(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
      int sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return op[1] ? 32'h0 : 32'h8000_0000;
      case (op)
         2'd0:    return sa / sb;
         2'd1:    return a / b;
         2'd2:    return sa % sb;
         default: return a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [1:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b);
`ifdef INT_DIV_EARLY_OUT_EN
      logic [W-1:0] mag;
      int bits;
`endif
      if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
`ifdef INT_DIV_EARLY_OUT_EN
      mag = (!op[0] && a[W-1]) ? -a : a;
      if (mag == 0) return 2;
      bits = 0;
      while (mag != 0) begin
         bits++;
         mag = mag >> 1;
      end
      return bits + 2;
`else
      return W + 2;
`endif
   endfunction

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   // Called at a negedge; presents the uop for one cycle and leaves cyc=1 (first cycle after accept).
   task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [6:0] sqn, input logic [6:0] tag, input logic [4:0] nm);
      IN_valid = 1'b1; IN_op = op; IN_srcA = a; IN_srcB = b;
      IN_sqN = sqn; IN_tagDst = tag; IN_nmDst = nm;
      @(negedge clk);
      IN_valid = 1'b0;
      cyc = 1;
   endtask

   task automatic wait_valid();
      while (OUT_valid !== 1'b1 && cyc < 100) tick();
   endtask

   task automatic test_reset();
      nReset = 1'b0; IN_valid = 1'b0; IN_op = 0; IN_srcA = 0; IN_srcB = 0;
      IN_sqN = 0; IN_tagDst = 0; IN_nmDst = 0; IN_branchTaken = 0; IN_branchSqN = 0;
      IN_wbAvail = 1'b1;
      repeat (3) @(negedge clk);
      nReset = 1'b1;
      @(negedge clk);
      n_vec++;
      if ({OUT_busy, OUT_valid} !== 2'b00) begin
         n_err++; $display("FAIL reset_ctrl busy/valid=%b expected 00", {OUT_busy, OUT_valid});
      end
      n_vec++;
      if ({OUT_result, OUT_sqN, OUT_tagDst, OUT_nmDst, OUT_divZero} !== '0) begin
         n_err++; $display("FAIL reset_data result=%h sqN=%h tag=%h nm=%h dz=%b expected all 0",
                           OUT_result, OUT_sqN, OUT_tagDst, OUT_nmDst, OUT_divZero);
      end
   endtask

   task automatic test_directed();
      logic [1:0]   ops [10] = '{0, 2, 1, 3, 0, 2, 1, 1, 0, 2};
      logic [W-1:0] as  [10] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 100, 100, 32'h8000_0000,
                                 32'h8000_0000, 5, 1000, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
      logic [W-1:0] bs  [10] = '{2, 2, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 7, 0, 0};
      logic [W-1:0] exp [10] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h64,
                                 32'h8000_0000, 32'h0, 5, 32'h8E, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
      for (int i = 0; i < 10; i++) begin
         issue(ops[i], as[i], bs[i], 7'(i), 7'(i + 3), 5'(i + 1));
         wait_valid();
         n_vec++;
         if (OUT_result !== exp[i] || OUT_valid !== 1'b1) begin
            n_err++; $display("FAIL dir_result[%0d] got %h valid=%b expected %h", i, OUT_result,
                              OUT_valid, exp[i]);
         end
         n_vec++;
         if (cyc != ref_lat(ops[i], as[i], bs[i]) || OUT_divZero !== (bs[i] == 0)) begin
            n_err++; $display("FAIL dir_lat[%0d] cycle=%0d dz=%b expected cycle=%0d dz=%b", i, cyc,
                              OUT_divZero, ref_lat(ops[i], as[i], bs[i]), bs[i] == 0);
         end
         tick();
         n_vec++;
         if ({OUT_valid, OUT_busy} !== 2'b00) begin
            n_err++; $display("FAIL dir_release[%0d] valid/busy=%b expected 00", i,
                              {OUT_valid, OUT_busy});
         end
      end
   endtask

   function automatic logic [W-1:0] pick(input int sel);
      case (sel)
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 300));
         default: return $urandom;
      endcase
   endfunction

   task automatic test_random();
      logic [1:0] op; logic [W-1:0] a, b; logic [6:0] sq, tg; logic [4:0] nm;
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = pick($urandom_range(0, 6));
         b  = pick($urandom_range(0, 6));
         sq = 7'($urandom); tg = 7'($urandom); nm = 5'($urandom);
         issue(op, a, b, sq, tg, nm);
         wait_valid();
         n_vec++;
         if (OUT_result !== ref_res(op, a, b) || OUT_valid !== 1'b1) begin
            n_err++; $display("FAIL rnd_result op=%0d a=%h b=%h got %h expected %h", op, a, b,
                              OUT_result, ref_res(op, a, b));
         end
         n_vec++;
         if (cyc != ref_lat(op, a, b)) begin
            n_err++; $display("FAIL rnd_latency op=%0d a=%h b=%h got %0d expected %0d", op, a, b,
                              cyc, ref_lat(op, a, b));
         end
         n_vec++;
         if ({OUT_sqN, OUT_tagDst, OUT_nmDst, OUT_divZero} !== {sq, tg, nm, b == 0}) begin
            n_err++; $display("FAIL rnd_tags got %h/%h/%h/%b expected %h/%h/%h/%b", OUT_sqN,
                              OUT_tagDst, OUT_nmDst, OUT_divZero, sq, tg, nm, b == 0);
         end
         tick();
      end
   endtask

   task automatic test_flush();
      logic seen;
      logic [6:0] br [2] = '{7'd8, 7'd12};
      for (int k = 0; k < 2; k++) begin
         issue(2'd1, 1000, 7, 7'd10, 7'd5, 5'd5);
         while (cyc < 5) tick();
         IN_branchTaken = 1'b1; IN_branchSqN = br[k];
         tick();
         IN_branchTaken = 1'b0;
         if (k == 0) begin
            n_vec++;
            if (OUT_busy !== 1'b0) begin
               n_err++; $display("FAIL flush_run busy=%b expected 0 in cycle 6", OUT_busy);
            end
            seen = 1'b0;
            repeat (40) begin
               tick();
               if (OUT_valid === 1'b1) seen = 1'b1;
            end
            n_vec++;
            if (seen !== 1'b0) begin
               n_err++; $display("FAIL flush_noresult valid seen=%b expected 0", seen);
            end
         end else begin
            wait_valid();
            n_vec++;
            if (OUT_result !== 32'h8E || cyc != ref_lat(2'd1, 1000, 7)) begin
               n_err++; $display("FAIL flush_older result=%h cycle=%0d expected 8e cycle=%0d",
                                 OUT_result, cyc, ref_lat(2'd1, 1000, 7));
            end
            tick();
         end
      end
      // Kill at accept, including a wrapped sqN compare (2 is younger than 126 modulo 128).
      for (int k = 0; k < 2; k++) begin
         IN_branchTaken = 1'b1;
         IN_branchSqN = (k == 0) ? 7'd8 : 7'd126;
         issue(2'd1, 9, 3, (k == 0) ? 7'd10 : 7'd2, 7'd1, 5'd1);
         IN_branchTaken = 1'b0;
         n_vec++;
         if (OUT_busy !== 1'b0) begin
            n_err++; $display("FAIL flush_accept[%0d] busy=%b expected 0", k, OUT_busy);
         end
      end
      // Kill while holding the result in DONE.
      IN_wbAvail = 1'b0;
      issue(2'd1, 9, 3, 7'd20, 7'd2, 5'd2);
      wait_valid();
      IN_branchTaken = 1'b1; IN_branchSqN = 7'd19;
      tick();
      IN_branchTaken = 1'b0; IN_wbAvail = 1'b1;
      n_vec++;
      if ({OUT_valid, OUT_busy} !== 2'b00) begin
         n_err++; $display("FAIL flush_done valid/busy=%b expected 00", {OUT_valid, OUT_busy});
      end
   endtask

   task automatic test_hold_back_to_back();
      IN_wbAvail = 1'b0;
      issue(2'd1, 1000, 7, 7'd33, 7'd44, 5'd9);
      wait_valid();
      repeat (5) begin
         n_vec++;
         if (OUT_valid !== 1'b1 || OUT_result !== 32'h8E || OUT_tagDst !== 7'd44) begin
            n_err++; $display("FAIL hold valid=%b result=%h tag=%h expected 1/8e/2c", OUT_valid,
                              OUT_result, OUT_tagDst);
         end
         tick();
      end
      IN_wbAvail = 1'b1;
      tick();
      n_vec++;
      if (OUT_valid !== 1'b0) begin
         n_err++; $display("FAIL hold_release valid=%b expected 0", OUT_valid);
      end
      issue(2'd1, 9, 3, 7'd34, 7'd45, 5'd10);
      n_vec++;
      if (OUT_busy !== 1'b1) begin
         n_err++; $display("FAIL b2b_accept busy=%b expected 1", OUT_busy);
      end
      wait_valid();
      n_vec++;
      if (OUT_result !== 32'h3 || OUT_valid !== 1'b1) begin
         n_err++; $display("FAIL b2b_result got %h expected 3", OUT_result);
      end
      tick();
   endtask

   task automatic test_async_reset();
      issue(2'd1, 32'hFFFF_FFFF, 3, 7'd55, 7'd66, 5'd17);
      while (cyc < 10) tick();
      #2 nReset = 1'b0;
      #1;
      n_vec++;
      if ({OUT_busy, OUT_valid, OUT_result, OUT_sqN, OUT_tagDst, OUT_nmDst, OUT_divZero} !== '0) begin
         n_err++; $display("FAIL async_reset busy=%b valid=%b result=%h sqN=%h tag=%h expected 0",
                           OUT_busy, OUT_valid, OUT_result, OUT_sqN, OUT_tagDst);
      end
      @(negedge clk);
      nReset = 1'b1;
      tick();
      issue(2'd1, 9, 3, 7'd1, 7'd2, 5'd3);
      wait_valid();
      n_vec++;
      if (OUT_result !== 32'h3 || OUT_valid !== 1'b1) begin
         n_err++; $display("FAIL post_reset result=%h valid=%b expected 3/1", OUT_result, OUT_valid);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_flush();
      test_hold_back_to_back();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
